// File: rtl/tm1638_sio_sequencer_if.sv
// Request/response channel between the TM1638 refresh logic and the sio sequencer.
interface tm1638_sio_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_byte;
   logic       req_read;
   logic       req_last;
   logic       rsp_valid;
   logic [7:0] rsp_byte;

   modport master (
      output req_valid, req_byte, req_read, req_last,
      input  req_ready, rsp_valid, rsp_byte
   );

   modport slave (
      input  req_valid, req_byte, req_read, req_last,
      output req_ready, rsp_valid, rsp_byte
   );
endinterface

// File: rtl/tm1638_sio_sequencer.sv
// TM1638 3-wire bus sequencer: frames request bytes under strobe, shifts LSB-first, reads key bytes.
// Optional busy/frame_count status logic is built only with TM1638_SIO_SEQUENCER_STATUS_EN defined.
module tm1638_sio_sequencer #(
   parameter int clk_mhz     = 50,
   parameter int sio_khz     = 500,
   parameter int turn_cycles = 2 * clk_mhz
) (
   input  logic                         clk,
   input  logic                         rst,
   tm1638_sio_sequencer_if.slave        bus,
   output logic                         sio_clk,
   output logic                         sio_stb,
   output logic                         sio_data_out,
   output logic                         sio_data_oe,
   input  logic                         sio_data_in,
   output logic                         busy,
   output logic [15:0]                  frame_count
);
   localparam int HP_RAW  = (clk_mhz * 1000) / (2 * sio_khz);
   localparam int HP      = (HP_RAW < 1) ? 1 : HP_RAW;
   localparam int TURN    = (turn_cycles < 1) ? 1 : turn_cycles;
   localparam int CNT_MAX = (HP > TURN) ? HP : TURN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HP - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_TURN, S_LOW, S_HIGH, S_GAP, S_HOLD, S_RECOVER
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             rd_q, rd_d;
   logic             last_q, last_d;
   logic [7:0]       byte_q, byte_d;
   logic [7:0]       rx_q, rx_d;
   logic             clk_q, clk_d;
   logic             stb_q, stb_d;
   logic             dout_q, dout_d;
   logic             oe_q, oe_d;
   logic             ready_q, ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_byte_q, rsp_byte_d;

   logic hs, hp_done, turn_done;
   assign hs        = bus.req_valid && ready_q;
   assign hp_done   = (cnt_q == HP_LAST);
   assign turn_done = (cnt_q == TURN_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      bit_d       = bit_q;
      rd_d        = rd_q;
      last_d      = last_q;
      byte_d      = byte_q;
      rx_d        = rx_q;
      clk_d       = clk_q;
      stb_d       = stb_q;
      dout_d      = dout_q;
      oe_d        = oe_q;
      rsp_valid_d = 1'b0;
      rsp_byte_d  = rsp_byte_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (hs) begin
               byte_d  = bus.req_byte;
               rd_d    = bus.req_read;
               last_d  = bus.req_last;
               bit_d   = '0;
               stb_d   = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (hp_done) begin
               if (rd_q) begin
                  state_d = S_TURN;
                  oe_d    = 1'b0;
               end else begin
                  state_d = S_LOW;
                  clk_d   = 1'b0;
                  dout_d  = byte_q[0];
                  oe_d    = 1'b1;
               end
            end
         end
         S_TURN: begin
            if (turn_done) begin
               state_d = S_LOW;
               clk_d   = 1'b0;
               oe_d    = 1'b0;
            end
         end
         S_LOW: begin
            if (hp_done) begin
               state_d = S_HIGH;
               clk_d   = 1'b1;
            end
         end
         S_HIGH: begin
            // The device has held its bit since our falling edge; capture it as clk rises.
            if (rd_q && (cnt_q == '0)) rx_d[bit_q] = sio_data_in;
            if (hp_done) begin
               if (bit_q == 3'd7) begin
                  if (rd_q) begin
                     rsp_valid_d = 1'b1;
                     rsp_byte_d  = rx_d;
                  end
                  state_d = last_q ? S_HOLD : S_GAP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  state_d = S_LOW;
                  clk_d   = 1'b0;
                  if (!rd_q) dout_d = byte_q[bit_d];
               end
            end
         end
         S_GAP: begin
            cnt_d = '0;
            if (hs) begin
               byte_d = bus.req_byte;
               rd_d   = bus.req_read;
               last_d = bus.req_last;
               bit_d  = '0;
               // Only a write-to-read change needs the bus released for the device.
               if (bus.req_read && !rd_q) begin
                  state_d = S_TURN;
                  oe_d    = 1'b0;
               end else begin
                  state_d = S_LOW;
                  clk_d   = 1'b0;
                  if (bus.req_read) begin
                     oe_d = 1'b0;
                  end else begin
                     oe_d   = 1'b1;
                     dout_d = bus.req_byte[0];
                  end
               end
            end
         end
         S_HOLD: begin
            if (hp_done) begin
               state_d = S_RECOVER;
               stb_d   = 1'b1;
               oe_d    = 1'b0;
               dout_d  = 1'b1;
            end
         end
         S_RECOVER: begin
            if (hp_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;
      ready_d = (state_d == S_IDLE) || (state_d == S_GAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         rd_q        <= 1'b0;
         last_q      <= 1'b0;
         clk_q       <= 1'b1;
         stb_q       <= 1'b1;
         dout_q      <= 1'b1;
         oe_q        <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_byte_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         rd_q        <= rd_d;
         last_q      <= last_d;
         clk_q       <= clk_d;
         stb_q       <= stb_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_byte_q  <= rsp_byte_d;
      end
   end

   always_ff @(posedge clk) begin
      byte_q <= byte_d;
      rx_q   <= rx_d;
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_byte  = rsp_byte_q;
   assign sio_clk       = clk_q;
   assign sio_stb       = stb_q;
   assign sio_data_out  = dout_q;
   assign sio_data_oe   = oe_q;

`ifdef TM1638_SIO_SEQUENCER_STATUS_EN
   logic [15:0] fc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fc_q <= '0;
      end else if (!stb_q && stb_d) begin
         fc_q <= fc_q + 16'd1;
      end
   end

   assign busy        = !stb_q || (state_q == S_RECOVER);
   assign frame_count = fc_q;
`else
   assign busy        = 1'b0;
   assign frame_count = '0;
`endif
endmodule

// File: tb/tb_tm1638_sio_sequencer.sv
// Randomized scoreboard bench for tm1638_sio_sequencer with a TM1638 device model on the data pin.
module tb_tm1638_sio_sequencer;
   localparam int HP   = 50;
   localparam int TURN = 100;
`ifdef TM1638_SIO_SEQUENCER_STATUS_EN
   localparam bit STATUS = 1'b1;
`else
   localparam bit STATUS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sio_clk, sio_stb, sio_data_out, sio_data_oe;
   logic        sio_data_in = 1'b1;
   logic        busy;
   logic [15:0] frame_count;

   tm1638_sio_sequencer_if bus();

   tm1638_sio_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .sio_clk      (sio_clk),
      .sio_stb      (sio_stb),
      .sio_data_out (sio_data_out),
      .sio_data_oe  (sio_data_oe),
      .sio_data_in  (sio_data_in),
      .busy         (busy),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_rsp[$];
   logic [7:0] exp_wr[$];
   logic [7:0] dev_q[$];
   int         exp_len[$];
   logic [7:0] txn_b[$];
   bit         txn_r[$];
   bit         abort_flag = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus monitor, device model and scoreboard.
   logic       prev_clk = 1'b1, prev_stb = 1'b1;
   int         stb_run = 0, oe_run = 0, wbit = 0, rbit = 0, prev_kind = 0, exp_fc = 0;
   logic [7:0] wsh = '0, dev_cur = '0;

   always @(negedge clk) begin
      if (rst || abort_flag) begin
         prev_clk  = 1'b1;
         prev_stb  = 1'b1;
         stb_run   = 0;
         oe_run    = 0;
         wbit      = 0;
         rbit      = 0;
         prev_kind = 0;
         if (rst) exp_fc = 0;
      end else begin
         if (bus.rsp_valid) begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else chk("rsp_byte", {24'd0, bus.rsp_byte}, {24'd0, exp_rsp.pop_front()});
         end
         if (prev_stb && !sio_stb) begin
            stb_run   = 0;
            oe_run    = 0;
            prev_kind = 0;
            wbit      = 0;
            rbit      = 0;
            chk("busy_open", {31'd0, busy}, {31'd0, STATUS});
         end
         if (!sio_stb) begin
            stb_run++;
            if (prev_clk && !sio_clk && !sio_data_oe) begin
               if (rbit == 0) begin
                  if (prev_kind != 2) chk("turnaround_oe_low", {31'd0, oe_run >= TURN}, 32'd1);
                  if (dev_q.size() == 0) begin
                     chk("device_byte_available", 32'd0, 32'd1);
                     dev_cur = 8'hFF;
                  end else begin
                     dev_cur = dev_q.pop_front();
                  end
               end
               sio_data_in = dev_cur[rbit];
               rbit++;
               if (rbit == 8) begin
                  rbit      = 0;
                  prev_kind = 2;
               end
            end
            if (!prev_clk && sio_clk && sio_data_oe) begin
               wsh[wbit] = sio_data_out;
               wbit++;
               if (wbit == 8) begin
                  wbit      = 0;
                  prev_kind = 1;
                  if (exp_wr.size() == 0) chk("write_unexpected", {24'd0, wsh}, 32'hFFFF_FFFF);
                  else chk("write_byte", {24'd0, wsh}, {24'd0, exp_wr.pop_front()});
               end
            end
            if (sio_data_oe) oe_run = 0;
            else if (sio_clk) oe_run++;
         end
         if (!prev_stb && sio_stb) begin
            exp_fc = (exp_fc + 1) & 16'hFFFF;
            if (exp_len.size() == 0) chk("stb_rise_unexpected", stb_run, 32'hFFFF_FFFF);
            else chk("stb_low_cycles", stb_run, exp_len.pop_front());
            chk("frame_count", {16'd0, frame_count}, STATUS ? exp_fc : 32'd0);
            chk("busy_recover", {31'd0, busy}, {31'd0, STATUS});
         end
         prev_clk = sio_clk;
         prev_stb = sio_stb;
      end
   end

   // Stimulus: caller is always positioned at a negedge.
   task automatic send(input logic [7:0] b, input bit rd, input bit last, output int waited);
      bus.req_valid = 1'b1;
      bus.req_byte  = rd ? 8'($urandom) : b;
      bus.req_read  = rd;
      bus.req_last  = last;
      waited = 0;
      while (!bus.req_ready && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) begin
         errors++;
         $display("FAIL req_accept: req_ready stayed 0 for %0d cycles, expected 1", waited);
         $fatal(1, "request never accepted");
      end
      @(negedge clk);
   endtask

   function automatic bit needs_turn(input int j);
      return txn_r[j] && (j == 0 || !txn_r[j-1]);
   endfunction

   // Reference model: stb-low length is SETUP + HOLD + 16 HP per byte + TURN per
   // write-to-read change + one GAP cycle per follow-on byte (valid held high).
   task automatic do_txn();
      int n, len, w, ew;
      n   = txn_b.size();
      len = 2 * HP + n * 16 * HP + (n - 1);
      for (int i = 0; i < n; i++) begin
         if (needs_turn(i)) len += TURN;
         if (txn_r[i]) begin
            dev_q.push_back(txn_b[i]);
            exp_rsp.push_back(txn_b[i]);
         end else begin
            exp_wr.push_back(txn_b[i]);
         end
      end
      exp_len.push_back(len);
      for (int i = 0; i < n; i++) begin
         send(txn_b[i], txn_r[i], i == n - 1, w);
         if (i > 0) begin
            ew = 16 * HP + ((i == 1) ? HP : 0) + (needs_turn(i - 1) ? TURN : 0);
            chk("gap_accept_latency", w, ew);
         end
      end
      bus.req_valid = 1'b0;
      txn_b.delete();
      txn_r.delete();
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_len.size() != 0 || exp_rsp.size() != 0) && n < 30000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30000) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d transactions still open, expected 0", exp_len.size());
      end
      repeat (HP + 4) @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_stb"},       {31'd0, sio_stb},       32'd1);
      chk({tag, "_sclk"},      {31'd0, sio_clk},       32'd1);
      chk({tag, "_dout"},      {31'd0, sio_data_out},  32'd1);
      chk({tag, "_oe"},        {31'd0, sio_data_oe},   32'd0);
      chk({tag, "_ready"},     {31'd0, bus.req_ready}, 32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
      chk({tag, "_rsp_byte"},  {24'd0, bus.rsp_byte},  32'd0);
      chk({tag, "_busy"},      {31'd0, busy},          32'd0);
      chk({tag, "_fcount"},    {16'd0, frame_count},   32'd0);
   endtask

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  falls, w;
      logic pc;
      bus.req_valid = 1'b0;
      bus.req_byte  = '0;
      bus.req_read  = 1'b0;
      bus.req_last  = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

      // Single write 0x40, closed immediately.
      txn_b = '{8'h40};
      txn_r = '{1'b0};
      do_txn();
      drain();
      chk("frame_count_first", {16'd0, frame_count}, STATUS ? 32'd1 : 32'd0);

      // Write 0x42 then read key byte 0xA5.
      txn_b = '{8'h42, 8'hA5};
      txn_r = '{1'b0, 1'b1};
      do_txn();
      drain();

      // Four consecutive reads under one strobe.
      txn_b = '{8'h11, 8'h22, 8'h44, 8'h88};
      txn_r = '{1'b1, 1'b1, 1'b1, 1'b1};
      do_txn();
      drain();

      // Command plus 16 data bytes, valid held high throughout.
      txn_b.push_back(8'hC0);
      txn_r.push_back(1'b0);
      for (int i = 0; i < 16; i++) begin
         txn_b.push_back(8'($urandom));
         txn_r.push_back(1'b0);
      end
      do_txn();
      drain();

      // Reset three cycles into bit 4 of a read.
      dev_q.push_back(8'($urandom));
      send(8'h00, 1'b1, 1'b1, w);
      bus.req_valid = 1'b0;
      falls = 0;
      pc    = sio_clk;
      for (int n = 0; n < 5000 && falls < 5; n++) begin
         @(negedge clk);
         if (pc && !sio_clk) falls++;
         pc = sio_clk;
      end
      chk("abort_reached_bit4", falls, 5);
      repeat (3) @(negedge clk);
      abort_flag = 1'b1;
      rst        = 1'b1;
      @(negedge clk);
      chk("abort_stb",       {31'd0, sio_stb},       32'd1);
      chk("abort_sclk",      {31'd0, sio_clk},       32'd1);
      chk("abort_oe",        {31'd0, sio_data_oe},   32'd0);
      chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      abort_flag = 1'b0;
      repeat (2 * HP) begin
         @(negedge clk);
         if (bus.rsp_valid) chk("abort_no_rsp", 32'd1, 32'd0);
      end
      chk("abort_dev_consumed", dev_q.size(), 0);

      // Randomized transactions.
      for (int t = 0; t < 8; t++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            txn_b.push_back(8'($urandom));
            txn_r.push_back(1'($urandom_range(0, 1)));
         end
         do_txn();
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      drain();

      chk("rsp_queue_empty",   exp_rsp.size(), 0);
      chk("write_queue_empty", exp_wr.size(),  0);
      chk("device_queue_empty", dev_q.size(),  0);
      chk("final_stb", {31'd0, sio_stb}, 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tm1638_sio_sequencer.md
Name: tm1638_sio_sequencer

Overview:
- Low-level transaction sequencer for the TM1638 3-wire serial bus (sio_clk, sio_stb, sio_data).
- Accepts a byte stream through a valid/ready request interface, frames bytes into strobe-delimited transactions and shifts them out LSB-first.
- Handles the write→read turnaround and returns key-scan bytes on a response pulse.
- Sits between the TM1638 board controller's refresh logic and the gpio pins; it is the only block that drives the bus.

Parameters:
- clk_mhz, 50, system clock frequency in MHz.
- sio_khz, 500, serial clock frequency in kHz.
- turn_cycles, 2*clk_mhz, clk cycles of bus release before the first read bit (≥1 µs TM1638 Twait).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request byte valid.
- req_ready  output  1  sequencer accepts a byte this cycle.
- req_byte  input  8  byte to send; ignored for reads.
- req_read  input  1  1 = read a byte from the device, 0 = write req_byte.
- req_last  input  1  close the transaction (raise strobe) after this byte.
- rsp_valid  output  1  one-cycle pulse, rsp_byte valid.
- rsp_byte  output  8  received byte, LSB first assembled.
- sio_clk  output  1  serial clock, idles high.
- sio_stb  output  1  strobe, active low.
- sio_data_out  output  1  serial data driven when sio_data_oe = 1.
- sio_data_oe  output  1  data pin output enable (top builds the tristate).
- sio_data_in  input  1  serial data pin readback.
- busy  output  1  transaction open (see Optional Feature).
- frame_count  output  16  completed transactions (see Optional Feature).

Behaviour:
- Half-period HP = clk_mhz*1000/(2*sio_khz), integer, minimum 1. Default HP = 50. The tick counter restarts on every state entry.
- Reset (synchronous, any state, including mid-byte):
  - sio_clk = 1, sio_stb = 1, sio_data_out = 1, sio_data_oe = 0.
  - req_ready = 0, rsp_valid = 0, rsp_byte = 0, busy = 0, frame_count = 0.
  - The state goes to IDLE. A partial byte is abandoned and no rsp_valid is issued.
- States: IDLE, SETUP, TURN, LOW, HIGH, GAP, HOLD, RECOVER.
- IDLE:
  - req_ready = 1 from the first cycle after rst deasserts.
  - On handshake: latch byte, read and last flags; sio_stb ← 0 next cycle; go to SETUP.
- SETUP: HP cycles with stb low and clk high. Then go to TURN if the latched byte is a read, otherwise LOW.
- TURN:
  - sio_data_oe = 0 for turn_cycles, then LOW.
  - TURN is entered only when the read is the first byte after a write or at transaction start. Consecutive reads skip it.
- LOW: sio_clk = 0 for HP cycles.
  - Write: sio_data_out = current bit and oe = 1, set on LOW entry.
  - Read: oe = 0.
- HIGH: sio_clk = 1 for HP cycles.
  - Read: sio_data_in is sampled on the HIGH entry cycle into bit index.
  - After bit 7, leave HIGH. Otherwise increment the bit index and go to LOW.
- After bit 7:
  - Read byte: rsp_valid pulses on the cycle after HIGH ends, carrying the 8 sampled bits.
  - last = 1 → HOLD. last = 0 → GAP.
- GAP:
  - stb stays low, clk high, oe keeps its last value. req_ready = 1.
  - Waits indefinitely for a request; no timeout.
  - On handshake go to LOW, or to TURN if the rule above applies.
- HOLD: HP cycles with clk high, then sio_stb ← 1 and oe ← 0. Go to RECOVER.
- RECOVER: HP cycles with stb high and req_ready = 0, then IDLE.
- frame_count increments on the cycle stb rises and wraps 0xFFFF→0.
- req_ready is 0 in SETUP, TURN, LOW, HIGH, HOLD and RECOVER. req_valid held in those states is not consumed.
- A write request arriving in GAP after a read: oe goes back to 1 at LOW entry; no turnaround is needed.
- Write-byte timing, handshake to stb rise: 1 + HP + 16·HP + HP cycles.

Optional Feature:
- Macro TM1638_SIO_SEQUENCER_STATUS_EN.
- Defined:
  - busy = 1 whenever sio_stb = 0 or the state is RECOVER.
  - frame_count operates as above.
- Undefined: busy and frame_count are tied to 0, and their logic is not built.
- The bus behaviour is identical in both cases.

Test Plan:
- Reset release, then a single write 0x40 with last = 1 (HP = 50):
  - stb low for exactly 900 cycles.
  - oe = 1 and sio_data_out sampled at the 8 rising sio_clk edges = 0,0,0,0,0,0,1,0.
  - frame_count = 1, rsp_valid never asserted.
- Write 0x42 (last = 0), then read with last = 1, sio_data_in driven from pattern 0xA5:
  - oe = 0 for ≥100 cycles before the first falling sio_clk of the read.
  - One rsp_valid pulse with rsp_byte = 0xA5.
- Four consecutive reads (0x11, 0x22, 0x44, 0x88), the last with last = 1:
  - Four rsp_valid pulses in order with those values.
  - No TURN between reads; stb stays low throughout.
- Write 0xC0 (last = 0), then 16 data bytes, the last with last = 1, with req_valid held high:
  - Each next byte is accepted on the first GAP cycle.
  - 17 bytes under one strobe; frame_count increments by exactly 1.
- rst asserted 3 cycles after bit 4 of a read starts:
  - Next cycle sio_stb = 1, sio_clk = 1, oe = 0.
  - No rsp_valid; req_ready = 1 the cycle after rst falls.
- Build without TM1638_SIO_SEQUENCER_STATUS_EN, then repeat the first scenario: identical bus waveform, busy = 0, frame_count = 0.
